// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 8-bit CPU: fetch/execute control word generation.
// Optional feature: define SEQ_JUMP_EN to decode opcode 0110 as JMP (otherwise NOP).
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_step,
  output logic       pc_oe,
  output logic       pc_ie,
  output logic       mar_ie,
  output logic       ram_oe,
  output logic       ir_ie,
  output logic       ir_oe,
  output logic       a_ie,
  output logic       a_oe,
  output logic       b_ie,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_ie,
  output logic [2:0] tstate,
  output logic       halted
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd5
  } tstate_t;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  tstate_t state, state_nx;
  logic    halt_q, halt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= T0;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nx;
      halt_q <= halt_nx;
    end
  end

  // HALT is sticky and ignores run; unreachable encodings recover to T0 on the next edge.
  always_comb begin
    state_nx = state;
    halt_nx  = halt_q;
    if (halt_q) begin
      state_nx = HALT;
    end else begin
      case (state)
        T0:      if (run) state_nx = T1;
        T1:      if (run) state_nx = T2;
        T2: begin
          if (run) begin
            if (opcode == OP_HLT) begin
              state_nx = HALT;
              halt_nx  = 1'b1;
            end else begin
              state_nx = T3;
            end
          end
        end
        T3:      if (run) state_nx = T4;
        T4:      if (run) state_nx = T0;
        HALT:    halt_nx = 1'b1;
        default: state_nx = T0;
      endcase
    end
  end

  always_comb begin
    pc_step = 1'b0;
    pc_oe   = 1'b0;
    pc_ie   = 1'b0;
    mar_ie  = 1'b0;
    ram_oe  = 1'b0;
    ir_ie   = 1'b0;
    ir_oe   = 1'b0;
    a_ie    = 1'b0;
    a_oe    = 1'b0;
    b_ie    = 1'b0;
    alu_oe  = 1'b0;
    alu_sub = 1'b0;
    out_ie  = 1'b0;
    if (rst && run && !halt_q) begin
      case (state)
        T0: begin
          pc_oe  = 1'b1;
          mar_ie = 1'b1;
        end
        T1: begin
          ram_oe  = 1'b1;
          ir_ie   = 1'b1;
          pc_step = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ir_oe  = 1'b1;
              mar_ie = 1'b1;
            end
            OP_OUT: begin
              a_oe   = 1'b1;
              out_ie = 1'b1;
            end
`ifdef SEQ_JUMP_EN
            OP_JMP: begin
              ir_oe = 1'b1;
              pc_ie = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_oe = 1'b1;
              a_ie   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_oe  = 1'b1;
              b_ie    = 1'b1;
              alu_sub = (opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_oe  = 1'b1;
            a_ie    = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = state;
  assign halted = halt_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control sequencer for the 8-bit CPU. It steps through fixed fetch and execute T-states and decodes the instruction-register opcode into the per-cycle control word. That word drives the program counter (`pc_step`, `pc_oe`, `pc_ie`) and the other bus-attached registers. It sits directly upstream of the program counter and owns every `ie`/`oe`/`step` strobe in the datapath.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `run`  in  1  1 = advance one T-state per clock; 0 = stall
- `opcode`  in  4  upper nibble of the instruction register; valid from T2 onward
- `pc_step`, `pc_oe`, `pc_ie`  out  1 each  program counter controls
- `mar_ie`  out  1  memory address register load
- `ram_oe`  out  1  RAM drives bus
- `ir_ie`, `ir_oe`  out  1 each  instruction register load / drive low nibble
- `a_ie`, `a_oe`  out  1 each  accumulator load / drive
- `b_ie`  out  1  B register load
- `alu_oe`  out  1  ALU result drives bus
- `alu_sub`  out  1  ALU subtract select
- `out_ie`  out  1  output register load
- `tstate`  out  3  current state: 0..4 = T0..T4, 5 = HALT
- `halted`  out  1  1 in HALT

## Operation
- State register: `tstate` plus a halt flag.
- Control outputs are combinational from (`tstate`, `opcode`, `run`, `rst`).
- Datapath registers latch on the same rising edge that advances the sequencer.
- Outputs are forced to all-zero when `rst`=0, when `run`=0, or in HALT.
- Fetch, identical for every opcode:
  - T0: `pc_oe`, `mar_ie`.
  - T1: `ram_oe`, `ir_ie`, `pc_step`.
- Execute, by opcode. Any control not listed is 0.
  - 0001 LDA:
    - T2: `ir_oe`, `mar_ie`.
    - T3: `ram_oe`, `a_ie`.
    - T4: none.
  - 0010 ADD:
    - T2: `ir_oe`, `mar_ie`.
    - T3: `ram_oe`, `b_ie`.
    - T4: `alu_oe`, `a_ie`.
  - 0011 SUB: as ADD, plus `alu_sub` in T3 and T4.
  - 1110 OUT:
    - T2: `a_oe`, `out_ie`.
    - T3, T4: none.
  - 1111 HLT: T2 outputs none; the clock edge in T2 enters HALT.
  - All other opcodes are NOP: T2–T4 outputs none.
- Transitions when `run`=1:
  - T0→T1→T2→T3→T4→T0.
  - Exception: HLT at T2 → HALT.
- `run`=0: `tstate` holds.
- HALT is sticky. Only reset exits it; `run` is ignored in HALT.
- Invariant: at most one of `pc_oe`, `ram_oe`, `ir_oe`, `a_oe`, `alu_oe` is asserted in any cycle.

## Timing
- Reset: `tstate`=0 and `halted`=0 immediately on `rst` falling, without waiting for a clock edge. All controls are 0 while `rst`=0.
- First rising edge after release with `run`=1 executes T0.
- Every instruction takes exactly 5 clocks, except HLT: 3 clocks, then HALT.
- `run` deasserted mid-instruction:
  - The current T-state's controls drop in the same cycle.
  - No edge takes effect until `run` returns.
  - Execution resumes at the same T-state.
- Reset mid-instruction abandons the instruction. The PC is not stepped further by the sequencer.
- `opcode` is don't-care in T0/T1. It is decoded only in T2–T4.
- `tstate` never takes the values 6 or 7. If it is ever found at 6 or 7, the next edge goes to T0.

## Configuration
- `SEQ_JUMP_EN`:
  - Defined: opcode 0110 is JMP. T2 asserts `ir_oe` and `pc_ie`; T3 and T4 assert none. The PC loads the low nibble (zero-extended) at the end of T2.
  - Undefined: 0110 decodes as NOP.
- No other opcode changes with the macro.

## Test plan
- Reset:
  - Stimulus: `rst`=0 asynchronously mid-cycle from `tstate`=3.
  - Response: `tstate`=0, `halted`=0 and all controls 0 before the next edge. After release with `run`=1, the first cycle shows `pc_oe`=`mar_ie`=1.
- LDA:
  - Stimulus: `opcode`=0001, `run`=1.
  - Response: control words exactly T0{`pc_oe`,`mar_ie`}, T1{`ram_oe`,`ir_ie`,`pc_step`}, T2{`ir_oe`,`mar_ie`}, T3{`ram_oe`,`a_ie`}, T4{}, then back to T0.
- SUB:
  - Stimulus: `opcode`=0011.
  - Response: `alu_sub`=1 only in T3/T4; T4 = {`alu_oe`,`a_ie`,`alu_sub`}.
- Stall:
  - Stimulus: drop `run` for 4 clocks during T3 of ADD.
  - Response: `tstate` stays 3 and controls are 0 throughout. On resume, T3 {`ram_oe`,`b_ie`} reappears.
- HLT:
  - Stimulus: `opcode`=1111.
  - Response: after the T2 edge, `tstate`=5 and `halted`=1, with controls 0 for 20+ clocks regardless of `run`. Only reset clears it.
- JMP:
  - Stimulus: `opcode`=0110.
  - Response, `SEQ_JUMP_EN` defined: T2 = {`ir_oe`,`pc_ie`}.
  - Response, undefined: T2 = {}.
  - Every cycle of every run: the bus-driver invariant holds.
